// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : FIFO-buffered UART transmitter with a valid/ready push port and
//             gap-free back-to-back framing. Optional parity bit is enabled
//             with the macro UART_TX_PARITY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int CLK_FREQ_HZ = 200000000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16,
  parameter int PARITY_ODD  = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [DATA_BITS-1:0]               tx_data,
  input  logic                               tx_valid,
  output logic                               tx_ready,
  output logic                               TxD,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int C_DIV    = CLK_FREQ_HZ / BAUD_RATE;
  localparam int C_BAUD_W = $clog2(C_DIV);
  localparam int C_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int C_CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int C_BIT_W  = 3;

  if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
      C_DIV < 2 || PARITY_ODD < 0 || PARITY_ODD > 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_tx_fifo: illegal parameter combination");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd4
  } state_t;
`endif

  // ---------------------------------------------------------------- FIFO
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [C_PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [C_CNT_W-1:0]   r_count;
  logic                 w_push, w_pop, w_empty;
  logic [DATA_BITS-1:0] w_rd_data;

  assign tx_ready   = (r_count != C_CNT_W'(FIFO_DEPTH));
  assign w_push     = tx_valid && tx_ready;
  assign w_empty    = (r_count == '0);
  assign w_rd_data  = r_mem[r_rd_ptr];
  assign fifo_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_W'(1);
        2'b01:   r_count <= r_count - C_CNT_W'(1);
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM
  state_t               r_state, w_state;
  logic [C_BAUD_W-1:0]  r_baud_cnt, w_baud_cnt;
  logic [C_BIT_W-1:0]   r_bit_cnt, w_bit_cnt;
  logic [DATA_BITS-1:0] r_shift, w_shift;
  logic                 r_txd, w_txd;
  logic                 w_tick, w_load;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity, w_parity;
`endif

  assign w_tick = (r_baud_cnt == C_BAUD_W'(C_DIV - 1));
  assign busy   = (r_state != S_IDLE);
  assign TxD    = r_txd;

  always_comb begin
    w_state    = r_state;
    w_shift    = r_shift;
    w_bit_cnt  = r_bit_cnt;
    w_txd      = r_txd;
    w_pop      = 1'b0;
    w_load     = 1'b0;
    w_baud_cnt = w_tick ? '0 : r_baud_cnt + C_BAUD_W'(1);
`ifdef UART_TX_PARITY_EN
    w_parity   = r_parity;
`endif
    case (r_state)
      S_IDLE: begin
        w_baud_cnt = '0;
        w_txd      = 1'b1;
        if (!w_empty) w_load = 1'b1;
      end
      S_START: begin
        if (w_tick) begin
          w_state   = S_DATA;
          w_txd     = r_shift[0];
          w_bit_cnt = '0;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (r_bit_cnt == C_BIT_W'(DATA_BITS - 1)) begin
            w_bit_cnt = '0;
`ifdef UART_TX_PARITY_EN
            w_state   = S_PARITY;
            w_txd     = r_parity;
`else
            w_state   = S_STOP;
            w_txd     = 1'b1;
`endif
          end else begin
            w_bit_cnt = r_bit_cnt + C_BIT_W'(1);
            w_shift   = r_shift >> 1;
            w_txd     = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          w_state   = S_STOP;
          w_txd     = 1'b1;
          w_bit_cnt = '0;
        end
      end
`endif
      S_STOP: begin
        if (w_tick) begin
          if (r_bit_cnt == C_BIT_W'(STOP_BITS - 1)) begin
            if (!w_empty) begin
              w_load = 1'b1;
            end else begin
              w_state = S_IDLE;
              w_txd   = 1'b1;
            end
          end else begin
            w_bit_cnt = r_bit_cnt + C_BIT_W'(1);
          end
        end
      end
      default: begin
        w_state = S_IDLE;
        w_txd   = 1'b1;
      end
    endcase

    // Shared frame launch: from IDLE or straight out of the last stop bit.
    if (w_load) begin
      w_pop      = 1'b1;
      w_state    = S_START;
      w_txd      = 1'b0;
      w_shift    = w_rd_data;
      w_baud_cnt = '0;
`ifdef UART_TX_PARITY_EN
      w_parity   = (^w_rd_data) ^ (PARITY_ODD != 0);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_txd      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state;
      r_baud_cnt <= w_baud_cnt;
      r_bit_cnt  <= w_bit_cnt;
      r_shift    <= w_shift;
      r_txd      <= w_txd;
`ifdef UART_TX_PARITY_EN
      r_parity   <= w_parity;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// Scoreboard bench for uart_tx_fifo: stimulus queues expected words, a line
// monitor decodes every frame off TxD cycle by cycle and compares.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam int DB = 7, SB = 2, PAR = 1, PODD = 1;
  localparam logic [7:0] SINGLE = 8'h55;
`else
  localparam int DB = 8, SB = 1, PAR = 0, PODD = 0;
  localparam logic [7:0] SINGLE = 8'hA5;
`endif
  localparam int DIVV      = 10;
  localparam int FRAME_CYC = (1 + DB + PAR + SB) * DIVV;

  logic          clk = 1'b0;
  logic          reset;
  logic [DB-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          TxD;
  logic          busy;
  logic [2:0]    fifo_count;

  uart_tx_fifo #(
    .CLK_FREQ_HZ(1000000), .BAUD_RATE(100000), .DATA_BITS(DB),
    .STOP_BITS(SB), .FIFO_DEPTH(4), .PARITY_ODD(PODD)
  ) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .TxD(TxD), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         gapless;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   frames_seen = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  function automatic logic [127:0] frame_wave(input logic [7:0] d);
    logic [15:0]  bits;
    logic [127:0] w;
    logic         p;
    bits    = '1;
    bits[0] = 1'b0;
    p       = (PODD != 0);
    for (int i = 0; i < DB; i++) begin
      bits[1+i] = d[i];
      p         = p ^ d[i];
    end
    if (PAR != 0) bits[1+DB] = p;
    w = '0;
    for (int j = 0; j < FRAME_CYC; j++) w[j] = bits[j / DIVV];
    return w;
  endfunction

  // Line monitor: one sample per cycle, a frame is FRAME_CYC samples from the start edge
  initial begin : monitor
    int           cyc;
    int           idle_run;
    int           start_gap;
    bit           active;
    logic [127:0] wave;
    exp_t         e;
    cyc = 0; idle_run = 1; start_gap = 1; active = 1'b0; wave = '0;
    forever begin
      @(negedge clk);
      if (reset || (active && !busy)) begin
        active   = 1'b0;
        idle_run = 1;
      end else begin
        if (!active) begin
          if (TxD == 1'b0) begin
            active = 1'b1; cyc = 0; wave = '0; start_gap = idle_run;
          end else begin
            idle_run++;
          end
        end
        if (active) begin
          wave[cyc] = TxD;
          cyc++;
          if (cyc == FRAME_CYC) begin
            active = 1'b0; idle_run = 0; frames_seen++;
            if (sb.size() == 0) begin
              n_checks++;
              $display("FAIL unexpected_frame: got frame %0h, required no frame", wave);
            end else begin
              e = sb.pop_front();
              check("frame_wave", wave, frame_wave(e.data));
              if (e.gapless) check("frame_gap", 128'(start_gap), 0);
            end
          end
        end
      end
    end
  end

  task automatic push_word(input logic [7:0] v, input bit gapless);
    bit acc;
    int n;
    tx_data  = v[DB-1:0];
    tx_valid = 1'b1;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 2000) begin
      acc = tx_ready;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (acc) sb.push_back(exp_t'{v, gapless});
    else begin
      n_checks++;
      $display("FAIL push_timeout: got no accept for %0h, required accept", v);
    end
  endtask

  task automatic busy_run(input int start, output int n);
    n = start;
    while (n < 5000) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int run;
    int peak;
    int low;
    int f0;
    reset = 1'b1; tx_valid = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);
    check("rst_txd", TxD, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", tx_ready, 1);
    check("rst_count", fifo_count, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Single frame: TxD drops one cycle after the push edge
    push_word(SINGLE, 1'b0);
    tx_valid = 1'b0;
    check("pre_start_txd", TxD, 1);
    check("pre_start_count", fifo_count, 1);
    @(negedge clk);
    check("start_txd", TxD, 0);
    check("start_busy", busy, 1);
    busy_run(1, run);
    check("single_busy_len", run, FRAME_CYC);
    check("single_idle_txd", TxD, 1);
    repeat (5) @(negedge clk);

    // Back-to-back: three pushes in consecutive cycles
    peak = 0;
    push_word(8'h00, 1'b0); if (int'(fifo_count) > peak) peak = int'(fifo_count);
    push_word(8'hFF, 1'b1); if (int'(fifo_count) > peak) peak = int'(fifo_count);
    push_word(8'h3C, 1'b1); if (int'(fifo_count) > peak) peak = int'(fifo_count);
    tx_valid = 1'b0;
    busy_run(2, run);
    check("b2b_peak", peak, 2);
    check("b2b_busy_len", run, 3 * FRAME_CYC);
    repeat (5) @(negedge clk);

    // Back-pressure: fill the FIFO behind an active frame
    push_word(8'h11, 1'b0);
    tx_valid = 1'b0;
    repeat (4) @(negedge clk);
    push_word(8'h22, 1'b1);
    push_word(8'h33, 1'b1);
    push_word(8'h44, 1'b1);
    push_word(8'h55, 1'b1);
    check("full_ready", tx_ready, 0);
    check("full_count", fifo_count, 4);
    tx_data  = DB'(8'h66);
    tx_valid = 1'b1;
    repeat (10) @(negedge clk);
    check("hold_count", fifo_count, 4);
    check("hold_ready", tx_ready, 0);
    push_word(8'h66, 1'b1);
    tx_valid = 1'b0;
    check("refill_count", fifo_count, 4);
    busy_run(1, run);
    check("drain_txd", TxD, 1);
    repeat (5) @(negedge clk);

    // Reset during data bit 3 with two words queued
    push_word(8'hA5, 1'b0);
    push_word(8'h5A, 1'b1);
    push_word(8'hC3, 1'b1);
    tx_valid = 1'b0;
    repeat (43) @(negedge clk);
    check("pre_reset_count", fifo_count, 2);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_txd", TxD, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_ready", tx_ready, 1);
    f0  = frames_seen;
    low = 0;
    repeat (300) @(negedge clk) if (TxD == 1'b0) low++;
    check("post_rst_low_cycles", low, 0);
    check("post_rst_frames", frames_seen, f0);

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
